control_unit: RTL

Microcoded control sequencer for the image-downsampling processor. It drives the CPU datapath control inputs: Op, shift, Read_AC, Read_RL, Write_RL, fetch, PC1, Decode, Mem_Read, Mem_Write and Ins_Con. It produces them cycle by cycle from the 16-bit instruction word on IM_OUT and the z_flag returned by the datapath. It sits directly beside CPU and replaces hand-driven control.

---
 rtl/control_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - microcoded control sequencer for the downsampling CPU datapath
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] IM_OUT,
    input  logic        z_flag,
    output logic        fetch,
    output logic        PC1,
    output logic        Decode,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        Ins_Con,
    output logic        Read_AC,
    output logic [14:0] Read_RL,
    output logic [17:0] Write_RL,
    output logic [2:0]  Op,
    output logic [3:0]  shift,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, PCINC, DECODE, EX1, EX2, EX3, HALT
    } state_t;

    localparam logic [3:0] OPC_ADD  = 4'd1;
    localparam logic [3:0] OPC_SUB  = 4'd2;
    localparam logic [3:0] OPC_AND  = 4'd3;
    localparam logic [3:0] OPC_OR   = 4'd4;
    localparam logic [3:0] OPC_INC  = 4'd5;
    localparam logic [3:0] OPC_SHL  = 4'd6;
    localparam logic [3:0] OPC_SHR  = 4'd7;
    localparam logic [3:0] OPC_STR  = 4'd8;
    localparam logic [3:0] OPC_LDM  = 4'd9;
    localparam logic [3:0] OPC_STM  = 4'd10;
    localparam logic [3:0] OPC_JMP  = 4'd11;
    localparam logic [3:0] OPC_JMPZ = 4'd12;
    localparam logic [3:0] OPC_LDAR = 4'd13;
    localparam logic [3:0] OPC_HALT = 4'd15;

    localparam logic [2:0] ALU_PASS = 3'b000;

    state_t      state, next_state;
    logic [15:0] ir, next_ir;

    logic [3:0]  dec_opc, dec_r;
    logic [3:0]  nx_opc, nx_r;
    logic        nx_alu, nx_r_ok;

    logic        n_fetch, n_pc1, n_decode, n_mem_read, n_mem_write, n_ins_con, n_read_ac;
    logic [14:0] n_read_rl;
    logic [17:0] n_write_rl;
    logic [2:0]  n_op;
    logic [3:0]  n_shift;

    assign dec_opc = IM_OUT[15:12];
    assign dec_r   = IM_OUT[11:8];
    assign nx_opc  = next_ir[15:12];
    assign nx_r    = next_ir[11:8];
    assign nx_alu  = (nx_opc >= OPC_ADD) && (nx_opc <= OPC_SHR);
    assign nx_r_ok = (nx_r < 4'd13);

    // State and instruction register; IR captures IM_OUT only while decoding
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ir    <= 16'h0000;
        end else begin
            state <= next_state;
            ir    <= next_ir;
        end
    end

    // Next-state sequencing: decode picks the execute path from IM_OUT and z_flag
    always_comb begin
        next_state = state;
        next_ir    = ir;
        case (state)
            IDLE:   if (start) next_state = FETCH;
            FETCH:  next_state = PCINC;
            PCINC:  next_state = DECODE;
            DECODE: begin
                next_ir = IM_OUT;
                case (dec_opc)
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_STR:
                        next_state = (dec_r < 4'd13) ? EX1 : FETCH;
                    OPC_INC, OPC_SHL, OPC_SHR, OPC_LDM, OPC_STM, OPC_JMP, OPC_LDAR:
                        next_state = EX1;
                    OPC_JMPZ: next_state = z_flag ? EX1 : FETCH;
                    OPC_HALT: next_state = HALT;
                    default:  next_state = FETCH;
                endcase
            end
            EX1: begin
                if ((ir[15:12] >= OPC_ADD && ir[15:12] <= OPC_SHR) ||
                    ir[15:12] == OPC_LDM || ir[15:12] == OPC_STM)
                    next_state = EX2;
                else
                    next_state = FETCH;
            end
            EX2: begin
                if (ir[15:12] == OPC_STM)
                    next_state = FETCH;
                else
                    next_state = EX3;
            end
            EX3:    next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Control word for the state being entered, so every output leaves a flop
    always_comb begin
        n_fetch     = 1'b0;
        n_pc1       = 1'b0;
        n_decode    = 1'b0;
        n_mem_read  = 1'b0;
        n_mem_write = 1'b0;
        n_ins_con   = 1'b0;
        n_read_ac   = 1'b0;
        n_read_rl   = 15'h0000;
        n_write_rl  = 18'h00000;
        n_op        = ALU_PASS;
        n_shift     = 4'h0;
        case (next_state)
            FETCH:  n_fetch  = 1'b1;
            PCINC:  n_pc1    = 1'b1;
            DECODE: n_decode = 1'b1;
            EX1: begin
                if (nx_alu) begin
                    n_read_ac = 1'b1;
                    if (nx_opc != OPC_INC && nx_r_ok) n_read_rl = 15'(1) << nx_r;
                    if (nx_opc == OPC_SHL || nx_opc == OPC_SHR) n_shift = nx_r;
                end else begin
                    case (nx_opc)
                        OPC_STR: begin
                            n_read_ac = 1'b1;
                            if (nx_r_ok) n_write_rl = 18'(1) << ({1'b0, nx_r} + 5'd1);
                        end
                        OPC_LDM: n_mem_read = 1'b1;
                        OPC_STM: begin
                            n_read_ac  = 1'b1;
                            n_write_rl = 18'h04000;
                        end
                        OPC_JMP, OPC_JMPZ: begin
                            n_ins_con  = 1'b1;
                            n_write_rl = 18'h10000;
                        end
                        OPC_LDAR: begin
                            n_ins_con  = 1'b1;
                            n_write_rl = 18'h08000;
                        end
                        default: ;
                    endcase
                end
            end
            EX2: begin
                if (nx_alu) begin
                    n_read_ac = 1'b1;
                    if (nx_opc != OPC_INC && nx_r_ok) n_read_rl = 15'(1) << nx_r;
                    n_op = nx_opc[2:0];
                    if (nx_opc == OPC_SHL || nx_opc == OPC_SHR) n_shift = nx_r;
                end else if (nx_opc == OPC_LDM) begin
                    n_read_rl = 15'h2000;
                end else if (nx_opc == OPC_STM) begin
                    n_mem_write = 1'b1;
                end
            end
            EX3: begin
                n_write_rl = 18'h00001;
                if (nx_opc == OPC_SHL || nx_opc == OPC_SHR) n_shift = nx_r;
            end
            default: ;
        endcase
    end

    // Output registers; reset clears every strobe including busy and done
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch     <= 1'b0;
            PC1       <= 1'b0;
            Decode    <= 1'b0;
            Mem_Read  <= 1'b0;
            Mem_Write <= 1'b0;
            Ins_Con   <= 1'b0;
            Read_AC   <= 1'b0;
            Read_RL   <= 15'h0000;
            Write_RL  <= 18'h00000;
            Op        <= ALU_PASS;
            shift     <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fetch     <= n_fetch;
            PC1       <= n_pc1;
            Decode    <= n_decode;
            Mem_Read  <= n_mem_read;
            Mem_Write <= n_mem_write;
            Ins_Con   <= n_ins_con;
            Read_AC   <= n_read_ac;
            Read_RL   <= n_read_rl;
            Write_RL  <= n_write_rl;
            Op        <= n_op;
            shift     <= n_shift;
            busy      <= (next_state != IDLE) && (next_state != HALT);
            done      <= (next_state == HALT);
        end
    end

endmodule
